// File: rtl/rv_enc_pkg.sv
// rv_enc_pkg: shared RV32I class/ALU codes, opcodes and encoder FSM state
package rv_enc_pkg;
  localparam logic [3:0] CLS_R      = 4'd0;
  localparam logic [3:0] CLS_I      = 4'd1;
  localparam logic [3:0] CLS_LOAD   = 4'd2;
  localparam logic [3:0] CLS_STORE  = 4'd3;
  localparam logic [3:0] CLS_BRANCH = 4'd4;
  localparam logic [3:0] CLS_JAL    = 4'd5;
  localparam logic [3:0] CLS_JALR   = 4'd6;
  localparam logic [3:0] CLS_LUI    = 4'd7;
  localparam logic [3:0] CLS_AUIPC  = 4'd8;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [1:0] {ST_STREAM, ST_PAD, ST_DONE} state_t;

  function automatic logic [2:0] alu_f3(input logic [3:0] op);
    case (op)
      ALU_SLL:           return 3'b001;
      ALU_SLT:           return 3'b010;
      ALU_SLTU:          return 3'b011;
      ALU_XOR:           return 3'b100;
      ALU_SRL, ALU_SRA:  return 3'b101;
      ALU_OR:            return 3'b110;
      ALU_AND:           return 3'b111;
      default:           return 3'b000;
    endcase
  endfunction
endpackage

// File: rtl/rv_field_pack.sv
// rv_field_pack: combinational request fields -> RV32I machine word plus legality
module rv_field_pack
  import rv_enc_pkg::*;
(
  input  logic [3:0]  cls,
  input  logic [3:0]  alu_op,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        legal
);
  logic       op_ok, is_shift, i12_ok, b13_ok, j21_ok, sh_ok;
  logic [2:0] f3;
  logic [6:0] f7;
  assign op_ok    = alu_op <= ALU_SRA;
  assign is_shift = alu_op == ALU_SLL || alu_op == ALU_SRL || alu_op == ALU_SRA;
  assign i12_ok   = &imm[31:11] || ~|imm[31:11];
  assign b13_ok   = (&imm[31:12] || ~|imm[31:12]) && !imm[0];
  assign j21_ok   = (&imm[31:20] || ~|imm[31:20]) && !imm[0];
  assign sh_ok    = ~|imm[31:5];
  assign f3       = alu_f3(alu_op);
  assign f7       = (alu_op == ALU_SUB || alu_op == ALU_SRA) ? 7'b0100000 : 7'b0000000;
  always_comb begin
    word  = '0;
    legal = 1'b0;
    case (cls)
      CLS_R: begin
        word  = {f7, rs2, rs1, f3, rd, OPC_OP};
        legal = op_ok;
      end
      CLS_I: begin
        word  = is_shift ? {f7, imm[4:0], rs1, f3, rd, OPC_OP_IMM} : {imm[11:0], rs1, f3, rd, OPC_OP_IMM};
        legal = op_ok && alu_op != ALU_SUB && (is_shift ? sh_ok : i12_ok);
      end
      CLS_LOAD: begin
        word  = {imm[11:0], rs1, funct3, rd, OPC_LOAD};
        legal = i12_ok && funct3 != 3'b011 && funct3 != 3'b110 && funct3 != 3'b111;
      end
      CLS_STORE: begin
        word  = {imm[11:5], rs2, rs1, funct3, imm[4:0], OPC_STORE};
        legal = i12_ok && funct3 <= 3'b010;
      end
      CLS_BRANCH: begin
        word  = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OPC_BRANCH};
        legal = b13_ok && funct3 != 3'b010 && funct3 != 3'b011;
      end
      CLS_JAL: begin
        word  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
        legal = j21_ok;
      end
      CLS_JALR: begin
        word  = {imm[11:0], rs1, 3'b000, rd, OPC_JALR};
        legal = i12_ok;
      end
      CLS_LUI, CLS_AUIPC: begin
        word  = {imm[31:12], rd, cls == CLS_LUI ? OPC_LUI : OPC_AUIPC};
        legal = ~|imm[11:0];
      end
      default: begin
        word  = '0;
        legal = 1'b0;
      end
    endcase
  end
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: streaming RV32I encoder with word addressing, error counting and NOP flush padding
module instr_encoder
  import rv_enc_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int PAD_WORDS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_class,
  input  logic [3:0]        in_alu_op,
  input  logic [2:0]        in_funct3,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err,
  output logic [7:0]        err_cnt,
  output logic              flush_done
);
  localparam logic [ADDR_W-1:0] PAD_MASK = ADDR_W'(PAD_WORDS - 1);
  state_t            state, state_nx;
  logic [ADDR_W-1:0] cnt;
  logic [31:0]       pk_word;
  logic              pk_legal, room, acc, aligned, st_load, pad_load;
  rv_field_pack u_pack (
    .cls    (in_class),
    .alu_op (in_alu_op),
    .funct3 (in_funct3),
    .rd     (in_rd),
    .rs1    (in_rs1),
    .rs2    (in_rs2),
    .imm    (in_imm),
    .word   (pk_word),
    .legal  (pk_legal)
  );
  // cnt is the address the next loaded word will carry
  assign room       = !out_valid || out_ready;
  assign in_ready   = state == ST_STREAM && room;
  assign acc        = in_valid && in_ready;
  assign aligned    = (cnt & PAD_MASK) == '0;
  assign st_load    = acc && pk_legal;
  assign pad_load   = state == ST_PAD && room && !aligned;
  assign flush_done = state == ST_DONE;
  always_comb begin
    state_nx = state == ST_STREAM ? (flush ? ST_PAD : ST_STREAM) :
               state == ST_PAD    ? (aligned && !out_valid ? ST_DONE : ST_PAD) :
                                    ST_STREAM;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_STREAM;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_instr <= '0;
      out_addr  <= '0;
      err       <= 1'b0;
      err_cnt   <= '0;
    end else begin
      state <= state_nx;
      err   <= acc && !pk_legal;
      if (acc && !pk_legal && err_cnt != 8'hFF)
        err_cnt <= err_cnt + 8'd1;
      if (st_load || pad_load) begin
        out_valid <= 1'b1;
        out_instr <= pad_load ? NOP_WORD : pk_word;
        out_addr  <= cnt;
        cnt       <= cnt + ADDR_W'(1);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: table-driven encoding checks plus stall, reset, wrap and flush sequences
module tb_instr_encoder;
  import rv_enc_pkg::*;
  typedef struct {
    logic [3:0]  cls;
    logic [3:0]  op;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        legal;
    logic [31:0] word;
  } vec_t;
  logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b1;
  logic        in_ready, out_valid, err, flush_done;
  logic [3:0]  in_class = '0, in_alu_op = '0;
  logic [2:0]  in_funct3 = '0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [31:0] in_imm = '0, out_instr;
  logic [9:0]  out_addr, exp_addr = '0;
  logic [7:0]  err_cnt, exp_ec = '0;
  int          nchk = 0, nerr = 0;
  vec_t        tv[$];
  always #5 clk = ~clk;
  instr_encoder #(.ADDR_W(10), .PAD_WORDS(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_class(in_class), .in_alu_op(in_alu_op), .in_funct3(in_funct3),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr), .err(err), .err_cnt(err_cnt),
    .flush_done(flush_done)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  function automatic vec_t mk(input logic [3:0] c, input logic [3:0] o, input logic [2:0] f,
                              input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                              input logic [31:0] i, input logic l, input logic [31:0] w);
    vec_t v;
    v.cls = c; v.op = o; v.f3 = f; v.rd = d; v.rs1 = s1; v.rs2 = s2; v.imm = i; v.legal = l; v.word = w;
    return v;
  endfunction
  task automatic drive(input vec_t v);
    in_class = v.cls; in_alu_op = v.op; in_funct3 = v.f3;
    in_rd = v.rd; in_rs1 = v.rs1; in_rs2 = v.rs2; in_imm = v.imm;
    in_valid = 1'b1;
  endtask
  task automatic send(input vec_t v, input string nm);
    int w;
    w = 0;
    drive(v);
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk({nm, " in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    if (v.legal) begin
      chk({nm, " out_valid"}, 32'(out_valid), 32'd1);
      chk({nm, " instr"}, out_instr, v.word);
      chk({nm, " addr"}, 32'(out_addr), 32'(exp_addr));
      chk({nm, " err"}, 32'(err), 32'd0);
      exp_addr++;
    end else begin
      exp_ec = exp_ec == 8'hFF ? 8'hFF : exp_ec + 8'd1;
      chk({nm, " out_valid"}, 32'(out_valid), 32'd0);
      chk({nm, " err"}, 32'(err), 32'd1);
    end
    chk({nm, " err_cnt"}, 32'(err_cnt), 32'(exp_ec));
  endtask
  task automatic pad_watch(input int nops, input string nm);
    int   seen;
    logic done;
    seen = 0;
    done = 1'b0;
    for (int i = 0; i < 30 && !done; i++) begin
      @(negedge clk);
      if (out_valid) begin
        chk({nm, " nop"}, out_instr, NOP_WORD);
        chk({nm, " nop addr"}, 32'(out_addr), 32'(exp_addr));
        exp_addr++;
        seen++;
      end
      chk({nm, " in_ready"}, 32'(in_ready), 32'd0);
      done = flush_done;
    end
    chk({nm, " nop count"}, 32'(seen), 32'(nops));
    chk({nm, " done"}, 32'(done), 32'd1);
  endtask
  initial begin
    tv.push_back(mk(CLS_R,      ALU_ADD, 3'd0, 5'd3, 5'd1,  5'd2, 32'd0,         1'b1, 32'h002081B3));
    tv.push_back(mk(CLS_R,      ALU_SUB, 3'd0, 5'd5, 5'd6,  5'd7, 32'd0,         1'b1, 32'h407302B3));
    tv.push_back(mk(CLS_I,      ALU_ADD, 3'd0, 5'd1, 5'd0,  5'd0, 32'hFFFFFFFF,  1'b1, 32'hFFF00093));
    tv.push_back(mk(CLS_I,      ALU_SRA, 3'd0, 5'd2, 5'd2,  5'd0, 32'd3,         1'b1, 32'h40315113));
    tv.push_back(mk(CLS_JAL,    ALU_ADD, 3'd0, 5'd1, 5'd0,  5'd0, 32'd8,         1'b1, 32'h008000EF));
    tv.push_back(mk(CLS_I,      ALU_ADD, 3'd0, 5'd1, 5'd0,  5'd0, 32'd2048,      1'b0, 32'h0));
    tv.push_back(mk(CLS_I,      ALU_SUB, 3'd0, 5'd1, 5'd0,  5'd0, 32'd0,         1'b0, 32'h0));
    tv.push_back(mk(CLS_LOAD,   ALU_ADD, 3'd2, 5'd5, 5'd10, 5'd0, 32'd16,        1'b1, 32'h01052283));
    tv.push_back(mk(CLS_STORE,  ALU_ADD, 3'd2, 5'd0, 5'd2,  5'd6, 32'd8,         1'b1, 32'h00612423));
    tv.push_back(mk(CLS_BRANCH, ALU_ADD, 3'd0, 5'd0, 5'd1,  5'd2, 32'd8,         1'b1, 32'h00208463));
    tv.push_back(mk(CLS_BRANCH, ALU_ADD, 3'd1, 5'd0, 5'd3,  5'd0, 32'hFFFFFFFC,  1'b1, 32'hFE019EE3));
    tv.push_back(mk(CLS_JALR,   ALU_ADD, 3'd3, 5'd1, 5'd5,  5'd0, 32'd4,         1'b1, 32'h004280E7));
    tv.push_back(mk(CLS_LUI,    ALU_ADD, 3'd0, 5'd7, 5'd0,  5'd0, 32'h12345000,  1'b1, 32'h123453B7));
    tv.push_back(mk(CLS_AUIPC,  ALU_ADD, 3'd0, 5'd1, 5'd0,  5'd0, 32'hFFFFF000,  1'b1, 32'hFFFFF097));
    tv.push_back(mk(CLS_I,      ALU_SLL, 3'd0, 5'd1, 5'd1,  5'd0, 32'd31,        1'b1, 32'h01F09093));
    tv.push_back(mk(CLS_R,      ALU_SRA, 3'd0, 5'd1, 5'd2,  5'd3, 32'd0,         1'b1, 32'h403150B3));
    tv.push_back(mk(CLS_R,      ALU_AND, 3'd0, 5'd1, 5'd1,  5'd1, 32'd0,         1'b1, 32'h0010F0B3));
    tv.push_back(mk(CLS_I,      ALU_ADD, 3'd0, 5'd1, 5'd0,  5'd0, 32'd2047,      1'b1, 32'h7FF00093));
    tv.push_back(mk(CLS_I,      ALU_ADD, 3'd0, 5'd1, 5'd0,  5'd0, 32'hFFFFF800,  1'b1, 32'h80000093));
    tv.push_back(mk(CLS_BRANCH, ALU_ADD, 3'd0, 5'd0, 5'd0,  5'd0, 32'd4094,      1'b1, 32'h7E000FE3));
    tv.push_back(mk(CLS_JAL,    ALU_ADD, 3'd0, 5'd0, 5'd0,  5'd0, 32'hFFF00000,  1'b1, 32'h8000006F));
    tv.push_back(mk(CLS_I,      ALU_SRL, 3'd0, 5'd1, 5'd0,  5'd0, 32'd32,        1'b0, 32'h0));
    tv.push_back(mk(CLS_I,      ALU_SLL, 3'd0, 5'd1, 5'd0,  5'd0, 32'hFFFFFFFF,  1'b0, 32'h0));
    tv.push_back(mk(CLS_I,      4'd10,   3'd0, 5'd1, 5'd0,  5'd0, 32'd0,         1'b0, 32'h0));
    tv.push_back(mk(CLS_R,      4'd10,   3'd0, 5'd1, 5'd0,  5'd0, 32'd0,         1'b0, 32'h0));
    tv.push_back(mk(CLS_LOAD,   ALU_ADD, 3'd3, 5'd1, 5'd0,  5'd0, 32'd0,         1'b0, 32'h0));
    tv.push_back(mk(CLS_STORE,  ALU_ADD, 3'd4, 5'd0, 5'd0,  5'd0, 32'd0,         1'b0, 32'h0));
    tv.push_back(mk(CLS_BRANCH, ALU_ADD, 3'd2, 5'd0, 5'd0,  5'd0, 32'd8,         1'b0, 32'h0));
    tv.push_back(mk(CLS_BRANCH, ALU_ADD, 3'd0, 5'd0, 5'd0,  5'd0, 32'd3,         1'b0, 32'h0));
    tv.push_back(mk(CLS_BRANCH, ALU_ADD, 3'd0, 5'd0, 5'd0,  5'd0, 32'd4096,      1'b0, 32'h0));
    tv.push_back(mk(CLS_JAL,    ALU_ADD, 3'd0, 5'd1, 5'd0,  5'd0, 32'h00100000,  1'b0, 32'h0));
    tv.push_back(mk(CLS_JAL,    ALU_ADD, 3'd0, 5'd1, 5'd0,  5'd0, 32'd5,         1'b0, 32'h0));
    tv.push_back(mk(CLS_JALR,   ALU_ADD, 3'd0, 5'd1, 5'd0,  5'd0, 32'd2048,      1'b0, 32'h0));
    tv.push_back(mk(CLS_LUI,    ALU_ADD, 3'd0, 5'd1, 5'd0,  5'd0, 32'h12345001,  1'b0, 32'h0));
    tv.push_back(mk(4'd9,       ALU_ADD, 3'd0, 5'd1, 5'd0,  5'd0, 32'd0,         1'b0, 32'h0));
    tv.push_back(mk(4'd15,      ALU_ADD, 3'd0, 5'd1, 5'd0,  5'd0, 32'd0,         1'b0, 32'h0));
    tv.push_back(mk(CLS_R,      ALU_OR,  3'd0, 5'd4, 5'd5,  5'd6, 32'd0,         1'b1, 32'h0062E233));

    repeat (3) @(negedge clk);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_instr", out_instr, 32'd0);
    chk("reset out_addr", 32'(out_addr), 32'd0);
    chk("reset err", 32'(err), 32'd0);
    chk("reset err_cnt", 32'(err_cnt), 32'd0);
    chk("reset flush_done", 32'(flush_done), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    foreach (tv[i]) send(tv[i], $sformatf("vec%0d", i));
    for (int i = 0; i < 1030; i++) send(tv[0], "wrap");
    for (int i = 0; i < 260; i++) send(tv[5], "sat");

    @(negedge clk);
    out_ready = 1'b0;
    drive(tv[1]);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("stall in_ready", 32'(in_ready), 32'd0);
      chk("stall out_valid", 32'(out_valid), 32'd1);
      chk("stall instr", out_instr, tv[1].word);
      chk("stall addr", 32'(out_addr), 32'(exp_addr));
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("midrst out_valid", 32'(out_valid), 32'd0);
    chk("midrst out_instr", out_instr, 32'd0);
    chk("midrst out_addr", 32'(out_addr), 32'd0);
    chk("midrst err", 32'(err), 32'd0);
    chk("midrst err_cnt", 32'(err_cnt), 32'd0);
    chk("midrst flush_done", 32'(flush_done), 32'd0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    rst = 1'b0;
    exp_addr = '0;
    exp_ec = '0;
    @(negedge clk);

    for (int i = 0; i < 3; i++) send(tv[i], "pre_flush");
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("pad in_ready", 32'(in_ready), 32'd0);
    pad_watch(1, "flush1");

    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("aligned no done yet", 32'(flush_done), 32'd0);
    chk("aligned no word", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("aligned done", 32'(flush_done), 32'd1);

    @(negedge clk);
    flush = 1'b1;
    send(tv[0], "coincident");
    flush = 1'b0;
    pad_watch(3, "flush3");
    @(negedge clk);
    send(tv[1], "post_flush");

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
